// File: rtl/imm_ext_pkg.sv
// rtl/imm_ext_pkg.sv - shared immediate-mode and occupancy encodings for decode/execute
package imm_ext_pkg;

    typedef enum logic [1:0] {
        IMM_ZERO  = 2'd0,
        IMM_SIGN  = 2'd1,
        IMM_UPPER = 2'd2,
        IMM_SHIFT = 2'd3
    } imm_mode_e;

    // Occupancy of the output/skid register pair
    typedef logic [1:0] occ_state_t;
    localparam occ_state_t OCC_EMPTY = 2'd0;
    localparam occ_state_t OCC_ONE   = 2'd1;
    localparam occ_state_t OCC_FULL  = 2'd2;

endpackage

// File: rtl/imm_ext_core.sv
// rtl/imm_ext_core.sv - combinational immediate extender (zero/sign/upper/shift-amount)
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W    = 8,
    parameter int OUT_W   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic [IN_W-1:0]  imm,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] ext
);

    if (IN_W < 2 || IN_W >= OUT_W) begin : g_bad_in_w
        $error("imm_ext_core: IN_W must satisfy 2 <= IN_W < OUT_W");
    end
    if (SHAMT_W < 1 || SHAMT_W > IN_W) begin : g_bad_shamt_w
        $error("imm_ext_core: SHAMT_W must satisfy 1 <= SHAMT_W <= IN_W");
    end

    always_comb begin
        ext = '0;
        case (imm_mode_e'(mode))
            IMM_ZERO:  ext = {{(OUT_W-IN_W){1'b0}}, imm};
            IMM_SIGN:  ext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
            IMM_UPPER: ext = {imm, {(OUT_W-IN_W){1'b0}}};
            // Only the low SHAMT_W bits form the shift amount; the rest are ignored
            IMM_SHIFT: ext = {{(OUT_W-SHAMT_W){imm[SHAMT_W-1]}}, imm[SHAMT_W-1:0]};
            default:   ext = '0;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - immediate extender with registered-ready two-entry skid buffer
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W    = 8,
    parameter int OUT_W   = 16,
    parameter int SHAMT_W = 4,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    if (TAG_W < 1) begin : g_bad_tag_w
        $error("imm_extend_pipe: TAG_W must be at least 1");
    end

    occ_state_t       state_q, state_d;
    logic             in_ready_q;
    logic [OUT_W-1:0] or_data_q, or_data_d, sk_data_q, sk_data_d;
    logic [TAG_W-1:0] or_tag_q, or_tag_d, sk_tag_q, sk_tag_d;
    logic [OUT_W-1:0] ext;
    logic             accept, transfer;

    // Extension happens once at accept; SK holds already-extended data
    imm_ext_core #(
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .SHAMT_W (SHAMT_W)
    ) u_core (
        .imm  (in_imm),
        .mode (in_mode),
        .ext  (ext)
    );

    assign accept    = in_valid & in_ready_q;
    assign transfer  = out_valid & out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != OCC_EMPTY);
    assign out_data  = or_data_q;
    assign out_tag   = or_tag_q;

    always_comb begin
        state_d   = state_q;
        or_data_d = or_data_q;
        or_tag_d  = or_tag_q;
        sk_data_d = sk_data_q;
        sk_tag_d  = sk_tag_q;
        case (state_q)
            OCC_EMPTY: begin
                if (accept) begin
                    state_d   = OCC_ONE;
                    or_data_d = ext;
                    or_tag_d  = in_tag;
                end
            end
            OCC_ONE: begin
                if (accept && transfer) begin
                    or_data_d = ext;
                    or_tag_d  = in_tag;
                end else if (accept) begin
                    state_d   = OCC_FULL;
                    sk_data_d = ext;
                    sk_tag_d  = in_tag;
                end else if (transfer) begin
                    state_d = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (transfer) begin
                    state_d   = OCC_ONE;
                    or_data_d = sk_data_q;
                    or_tag_d  = sk_tag_q;
                end
            end
            default: state_d = OCC_EMPTY;
        endcase
        // Flush wins over any concurrent accept or transfer
        if (flush) begin
            state_d = OCC_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= OCC_EMPTY;
            in_ready_q <= 1'b1;
            or_data_q  <= '0;
            or_tag_q   <= '0;
            sk_data_q  <= '0;
            sk_tag_q   <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != OCC_FULL);
            or_data_q  <= or_data_d;
            or_tag_q   <= or_tag_d;
            sk_data_q  <= sk_data_d;
            sk_tag_q   <= sk_tag_d;
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - scoreboard bench for imm_extend_pipe
module tb_imm_extend_pipe;

    localparam int IN_W = 8, OUT_W = 16, SHAMT_W = 4, TAG_W = 4;
    localparam int W_IN = 12, W_OUT = 32, W_SH = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [IN_W-1:0]  in_imm;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag, out_tag;
    logic [OUT_W-1:0] out_data;

    logic             w_flush, w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    logic [W_IN-1:0]  w_imm;
    logic [1:0]       w_mode;
    logic [TAG_W-1:0] w_tag, w_out_tag;
    logic [W_OUT-1:0] w_out_data;

    imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SHAMT_W(SHAMT_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
    );

    imm_extend_pipe #(.IN_W(W_IN), .OUT_W(W_OUT), .SHAMT_W(W_SH), .TAG_W(TAG_W)) dut_w (
        .clk(clk), .reset(reset), .flush(w_flush),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_imm(w_imm), .in_mode(w_mode), .in_tag(w_tag),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data), .out_tag(w_out_tag)
    );

    typedef struct {
        longint unsigned data;
        longint unsigned tag;
    } exp_t;

    exp_t q[$];
    exp_t wq[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(input string name, input longint unsigned got, input longint unsigned exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, got, exp);
    endtask

    // Reference extension computed arithmetically from the mode rules
    function automatic longint unsigned ref_ext(input longint unsigned imm, input int mode,
                                                input int iw, input int ow, input int sw);
        longint unsigned full, v, s;
        full = 64'd1 << ow;
        v    = imm % (64'd1 << iw);
        case (mode)
            0: return v;
            1: return (v >= (64'd1 << (iw - 1))) ? v + full - (64'd1 << iw) : v;
            2: return v * (64'd1 << (ow - iw));
            default: begin
                s = v % (64'd1 << sw);
                return (s >= (64'd1 << (sw - 1))) ? s + full - (64'd1 << sw) : s;
            end
        endcase
    endfunction

    // Issue side: record what the DUT is about to accept on the coming edge
    always @(negedge clk) begin
        if (reset || flush) q.delete();
        else if (in_valid && in_ready)
            q.push_back('{data: ref_ext(64'(in_imm), int'(in_mode), IN_W, OUT_W, SHAMT_W), tag: 64'(in_tag)});
        if (reset || w_flush) wq.delete();
        else if (w_in_valid && w_in_ready)
            wq.push_back('{data: ref_ext(64'(w_imm), int'(w_mode), W_IN, W_OUT, W_SH), tag: 64'(w_tag)});
    end

    // Monitor: compare every beat that will transfer on the coming edge
    logic             stall_seen = 1'b0;
    logic [OUT_W-1:0] st_data;
    logic [TAG_W-1:0] st_tag;
    exp_t             e, we;

    always @(negedge clk) begin
        if (reset || flush) begin
            stall_seen = 1'b0;
        end else begin
            if (stall_seen && out_valid) begin
                check("hold_data", 64'(out_data), 64'(st_data));
                check("hold_tag", 64'(out_tag), 64'(st_tag));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_beat: got data %0h tag %0h, required no output", out_data, out_tag);
                end else begin
                    e = q.pop_front();
                    check("out_data", 64'(out_data), e.data);
                    check("out_tag", 64'(out_tag), e.tag);
                end
            end
            stall_seen = out_valid && !out_ready;
            st_data    = out_data;
            st_tag     = out_tag;
        end
    end

    always @(negedge clk) begin
        if (!reset && !w_flush && w_out_valid && w_out_ready) begin
            if (wq.size() == 0) begin
                n_total++;
                $display("FAIL wide_unexpected_beat: got data %0h, required no output", w_out_data);
            end else begin
                we = wq.pop_front();
                check("wide_data", 64'(w_out_data), we.data);
                check("wide_tag", 64'(w_out_tag), we.tag);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int imm, input int mode, input int tag);
        in_valid = v;
        in_imm   = IN_W'(imm);
        in_mode  = 2'(mode);
        in_tag   = TAG_W'(tag);
    endtask

    int shift_vals[3] = '{'hF8, 'h07, 'h0F};
    int bp_vals[3]    = '{'h01, 'h80, 'h7F};
    int w_imms[3]     = '{'h800, 'hABC, 'h01F};
    int w_modes[3]    = '{1, 2, 3};
    bit acc;

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 0, 0, 0);
        w_flush = 1'b0; w_in_valid = 1'b0; w_imm = '0; w_mode = '0; w_tag = '0; w_out_ready = 1'b1;
        step(); step();
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_in_ready", 64'(in_ready), 1);
        check("rst_out_data", 64'(out_data), 0);
        check("rst_out_tag", 64'(out_tag), 0);
        step();

        // All four modes back to back, each visible one cycle after accept
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 'h85, i, i + 1);
            step();
            check("lat_modes", 64'(out_valid), 1);
        end
        drive(1'b0, 0, 0, 0);
        step();

        for (int i = 0; i < 3; i++) begin
            drive(1'b1, shift_vals[i], 3, i + 1);
            step();
        end
        drive(1'b0, 0, 0, 0);
        step();

        // Backpressure fills OR and SK, third input must wait
        out_ready = 1'b0;
        drive(1'b1, bp_vals[0], 1, 5);
        step();
        check("bp_ready_one", 64'(in_ready), 1);
        drive(1'b1, bp_vals[1], 1, 6);
        step();
        check("bp_ready_full", 64'(in_ready), 0);
        drive(1'b1, bp_vals[2], 1, 7);
        step();
        check("bp_still_full", 64'(in_ready), 0);
        out_ready = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 10 && !acc; k++) begin
            if (in_ready) acc = 1'b1;
            step();
        end
        check("bp_third_accepted", 64'(acc), 1);
        drive(1'b0, 0, 0, 0);
        repeat (3) step();

        // Flush while FULL with a concurrent valid input
        out_ready = 1'b0;
        drive(1'b1, 'h11, 0, 8);
        step();
        drive(1'b1, 'h12, 0, 9);
        step();
        drive(1'b1, 'h13, 0, 10);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 0, 0, 0);
        check("flush_out_valid", 64'(out_valid), 0);
        check("flush_in_ready", 64'(in_ready), 1);
        out_ready = 1'b1;
        drive(1'b1, 'h22, 1, 11);
        step();
        drive(1'b0, 0, 0, 0);
        check("flush_next_lat", 64'(out_valid), 1);
        repeat (2) step();

        // Reset mid-stream with an entry held and a new input offered
        out_ready = 1'b0;
        drive(1'b1, 'h33, 0, 12);
        step();
        reset = 1'b1;
        drive(1'b1, 'h44, 1, 13);
        step();
        reset = 1'b0;
        drive(1'b0, 0, 0, 0);
        check("mid_rst_out_valid", 64'(out_valid), 0);
        check("mid_rst_out_data", 64'(out_data), 0);
        check("mid_rst_out_tag", 64'(out_tag), 0);
        check("mid_rst_in_ready", 64'(in_ready), 1);
        out_ready = 1'b1;
        repeat (3) step();

        for (int c = 0; c < 400; c++) begin
            drive(($urandom % 4) != 0, int'($urandom), int'($urandom % 4), int'($urandom));
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 50) == 0;
            step();
        end
        flush = 1'b0;
        drive(1'b0, 0, 0, 0);
        out_ready = 1'b1;
        repeat (4) step();
        check("drain_empty", 64'(q.size()), 0);

        // Wider parametrisation
        for (int i = 0; i < 3; i++) begin
            w_in_valid = 1'b1;
            w_imm      = W_IN'(w_imms[i]);
            w_mode     = 2'(w_modes[i]);
            w_tag      = TAG_W'(i + 1);
            step();
        end
        w_in_valid = 1'b0;
        repeat (4) step();
        check("wide_drain_empty", 64'(wq.size()), 0);
        check("wide_ref_sign", ref_ext(64'h800, 1, W_IN, W_OUT, W_SH), 64'hFFFFF800);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
